// File: rtl/hera_spi_pkg.sv
// Shared definitions for the HERA SPI link. The memory manager's responder
// imports the same SPI mode constants.
package hera_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHAINED,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam int DEFAULT_WORD_BITS = 16;

  // Mode 0: SCK idles low, data is captured on the rising half of each bit.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hera_spi_tick.sv
// DIV-cycle down-counter for the SPI initiator; tick_o marks the last clk
// cycle of each SCK half-period. restart_i realigns the phase to a new bit.
module hera_spi_tick
  import hera_spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/hera_spi_initiator.sv
// HERA SPI initiator: mode-0 master shifting WORD_BITS-bit words MSB first,
// with CS framing, word chaining and a valid/ready word handshake.
module hera_spi_initiator
  import hera_spi_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS,
  parameter int DIV       = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_last,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs
);

  localparam int BW = cnt_width(WORD_BITS);
  localparam int GW = cnt_width(CS_GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

  spi_state_e           state_q;
  logic [WORD_BITS-1:0] tx_shift_q;
  logic [WORD_BITS-2:0] rx_shift_q;
  logic [WORD_BITS-1:0] rx_data_q;
  logic [WORD_BITS-1:0] rx_word_d;
  logic [BW-1:0]        bit_cnt_q;
  logic [GW-1:0]        gap_cnt_q;
  logic                 last_q;
  logic                 sck_q;
  logic                 cs_q;
  logic                 rx_valid_q;
  logic                 busy_q;

  logic accept;
  logic tick_en;
  logic phase_tick;
  logic final_fall;

  assign tx_ready   = (state_q == ST_IDLE) || (state_q == ST_CHAINED);
  assign accept     = tx_valid && tx_ready;
  assign tick_en    = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign final_fall = (state_q == ST_SHIFT) && phase_tick && sck_q && (bit_cnt_q == LAST_BIT);
  assign rx_word_d  = {rx_shift_q, spi_miso};

  // Restart on the last fall too, so the HOLD interval is exactly DIV cycles.
  hera_spi_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .restart_i(accept || final_fall),
    .en_i     (tick_en),
    .tick_o   (phase_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b0;
      sck_q      <= SPI_CPOL;
      cs_q       <= 1'b1;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_CHAINED: begin
          if (accept) begin
            state_q    <= ST_SHIFT;
            tx_shift_q <= tx_data;
            last_q     <= tx_last;
            bit_cnt_q  <= '0;
            sck_q      <= SPI_CPOL;
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (phase_tick) begin
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // Falling edge: capture at the end of the high phase, then advance MOSI.
              sck_q      <= 1'b0;
              rx_shift_q <= rx_word_d[WORD_BITS-2:0];
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= rx_word_d;
                rx_valid_q <= 1'b1;
                state_q    <= last_q ? ST_HOLD : ST_CHAINED;
              end else begin
                bit_cnt_q  <= bit_cnt_q + BW'(1);
                tx_shift_q <= {tx_shift_q[WORD_BITS-2:0], 1'b0};
              end
            end
          end
        end
        ST_HOLD: begin
          if (phase_tick) begin
            state_q   <= ST_GAP;
            cs_q      <= 1'b1;
            gap_cnt_q <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = tx_shift_q[WORD_BITS-1];
  assign spi_cs   = cs_q;

endmodule

// File: tb/tb_hera_spi_initiator.sv
// Directed bench for hera_spi_initiator: a DIV=2 instance with loopback or a
// mode-0 responder model, and a DIV=1 instance for back-to-back framing.
module tb_hera_spi_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        sel;
  logic        loop_en;
  logic [15:0] resp_word;
  logic [15:0] resp_sh;

  logic        a_rdy, a_rxv, a_busy, a_sck, a_mosi, a_cs, a_miso;
  logic [15:0] a_rxd;
  logic        b_rdy, b_rxv, b_busy, b_sck, b_mosi, b_cs;
  logic [15:0] b_rxd;

  assign a_miso = loop_en ? a_mosi : resp_sh[15];

  hera_spi_initiator #(.WORD_BITS(16), .DIV(2), .CS_GAP(2)) u_dut_a (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid & ~sel), .tx_ready(a_rdy), .rx_data(a_rxd), .rx_valid(a_rxv),
    .busy(a_busy), .spi_clk(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso), .spi_cs(a_cs)
  );

  hera_spi_initiator #(.WORD_BITS(16), .DIV(1), .CS_GAP(2)) u_dut_b (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid & sel), .tx_ready(b_rdy), .rx_data(b_rxd), .rx_valid(b_rxv),
    .busy(b_busy), .spi_clk(b_sck), .spi_mosi(b_mosi), .spi_miso(b_mosi), .spi_cs(b_cs)
  );

  logic        m_rdy, m_rxv, m_busy, m_sck, m_mosi, m_cs;
  logic [15:0] m_rxd;
  assign m_rdy  = sel ? b_rdy  : a_rdy;
  assign m_rxv  = sel ? b_rxv  : a_rxv;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_sck  = sel ? b_sck  : a_sck;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_cs   = sel ? b_cs   : a_cs;
  assign m_rxd  = sel ? b_rxd  : a_rxd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode-0 responder: MSB ready at CS fall, next bit after each SCK fall.
  always @(negedge a_cs) resp_sh = resp_word;
  always @(negedge a_sck) resp_sh = resp_sh << 1;

  // Scoreboard: expectations queued at offer time, checked on rx_valid.
  logic [15:0] exp_rx[$];
  logic [15:0] exp_tx[$];
  logic [15:0] mosi_cap = 16'h0;
  always @(posedge m_sck) mosi_cap = {mosi_cap[14:0], m_mosi};

  always @(negedge clk) begin
    if (m_rxv) begin
      logic [15:0] e;
      $display("rx word %h (mosi %h) at cycle %0d", m_rxd, mosi_cap, cyc);
      chk("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
      if (exp_rx.size() != 0) begin
        e = exp_rx.pop_front();
        chk("rx_data", 32'(m_rxd), 32'(e));
      end
      if (exp_tx.size() != 0) begin
        e = exp_tx.pop_front();
        chk("mosi_bits", 32'(mosi_cap), 32'(e));
      end
    end
  end

  int cs_rises = 0;
  always @(posedge a_cs) cs_rises++;

  // CS run lengths on the DIV=1 instance.
  int lo_run = 0;
  int hi_run = 0;
  bit seen_lo = 1'b0;
  int lo_runs[$];
  int hi_runs[$];
  always @(negedge clk) begin
    if (sel) begin
      if (!b_cs) begin
        if (hi_run > 0 && seen_lo) hi_runs.push_back(hi_run);
        hi_run = 0;
        lo_run++;
        seen_lo = 1'b1;
      end else begin
        if (lo_run > 0) lo_runs.push_back(lo_run);
        lo_run = 0;
        hi_run++;
      end
    end
  end

  task automatic offer(input logic [15:0] d, input logic l, input logic [15:0] exp_r, output int t0);
    bit ok = 1'b0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (m_rdy) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) chk("offer_accepted", 32'(m_rdy), 32'd1);
    else begin
      exp_rx.push_back(exp_r);
      exp_tx.push_back(d);
    end
    t0 = cyc;
    $display("tx word %h last %0b at cycle %0d", d, l, t0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  int ob_cs_first, ob_cs_last, ob_rxv_first, ob_rxv_n, ob_rdy_first, ob_rise_n, ob_rise_first;

  task automatic observe(input int t0, input int n, input bit toggle);
    logic prev_sck;
    int   off;
    ob_cs_first = -1; ob_cs_last = -1; ob_rxv_first = -1; ob_rxv_n = 0;
    ob_rdy_first = -1; ob_rise_n = 0; ob_rise_first = -1;
    prev_sck = m_sck;
    for (int i = 0; i < n; i++) begin
      off = cyc - t0;
      if (toggle) begin
        if (off < 60) begin
          tx_valid = off[0];
          tx_data  = 16'hDEAD;
          tx_last  = 1'b0;
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (!m_cs) begin
        if (ob_cs_first < 0) ob_cs_first = off;
        ob_cs_last = off;
      end
      if (m_rxv) begin
        if (ob_rxv_first < 0) ob_rxv_first = off;
        ob_rxv_n++;
      end
      if (m_rdy && ob_rdy_first < 0) ob_rdy_first = off;
      if (m_sck && !prev_sck) begin
        if (ob_rise_first < 0) ob_rise_first = off;
        ob_rise_n++;
      end
      prev_sck = m_sck;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, cs_base, cs_hi, sck_hi;
    bit got;
    rst_n = 1'b0; sel = 1'b0; loop_en = 1'b1;
    tx_valid = 1'b0; tx_data = 16'h0; tx_last = 1'b0;
    resp_word = 16'h0; resp_sh = 16'h0;
    repeat (3) @(negedge clk);

    chk("reset_cs", 32'(a_cs), 32'd1);
    chk("reset_sck", 32'(a_sck), 32'd0);
    chk("reset_mosi", 32'(a_mosi), 32'd0);
    chk("reset_rx_valid", 32'(a_rxv), 32'd0);
    chk("reset_rx_data", 32'(a_rxd), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_tx_ready", 32'(a_rdy), 32'd1);
    chk("reset_cs_b", 32'(b_cs), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback frame, DIV=2
    offer(16'hA5C3, 1'b1, 16'hA5C3, t0);
    observe(t0, 80, 1'b0);
    chk("t1_cs_first", ob_cs_first, 1);
    chk("t1_cs_last", ob_cs_last, 66);
    chk("t1_sck_rises", ob_rise_n, 16);
    chk("t1_first_rise", ob_rise_first, 3);
    chk("t1_rxv_at", ob_rxv_first, 65);
    chk("t1_rxv_count", ob_rxv_n, 1);
    chk("t1_ready_at", ob_rdy_first, 69);
    chk("t1_busy_end", 32'(m_busy), 32'd0);

    // Responder returns 3C5A while 1234 goes out
    loop_en = 1'b0;
    resp_word = 16'h3C5A;
    offer(16'h1234, 1'b1, 16'h3C5A, t0);
    observe(t0, 80, 1'b0);
    chk("t2_rxv_count", ob_rxv_n, 1);
    chk("t2_rx_data", 32'(m_rxd), 32'h3C5A);
    loop_en = 1'b1;

    // Chained words, second offered 5 cycles after the first completes
    cs_base = cs_rises;
    offer(16'h0001, 1'b0, 16'h0001, t0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (m_rxv) got = 1'b1;
      else @(negedge clk);
    end
    chk("t3_first_rxv", 32'(got), 32'd1);
    cs_hi = 0; sck_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_cs) cs_hi++;
      if (m_sck) sck_hi++;
    end
    chk("t3_wait_cs_high", cs_hi, 0);
    chk("t3_wait_sck_high", sck_hi, 0);
    chk("t3_wait_ready", 32'(m_rdy), 32'd1);
    chk("t3_wait_busy", 32'(m_busy), 32'd1);
    offer(16'hFFFF, 1'b1, 16'hFFFF, t1);
    observe(t1, 80, 1'b0);
    chk("t3_second_first_rise", ob_rise_first, 3);
    chk("t3_second_rxv_at", ob_rxv_first, 65);
    chk("t3_second_rxv_count", ob_rxv_n, 1);
    chk("t3_cs_last", ob_cs_last, 66);
    chk("t3_cs_rises", cs_rises - cs_base, 1);

    // tx_valid toggled with DEAD while shifting
    offer(16'h0F0F, 1'b1, 16'h0F0F, t0);
    observe(t0, 80, 1'b1);
    chk("t4_rxv_count", ob_rxv_n, 1);
    chk("t4_rx_data", 32'(m_rxd), 32'h0F0F);
    chk("t4_busy_end", 32'(m_busy), 32'd0);

    // Reset during bit 7
    offer(16'h5A5A, 1'b1, 16'h5A5A, t0);
    while (cyc - t0 < 31) @(negedge clk);
    chk("t5_sck_high_bit7", 32'(m_sck), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", 32'(a_cs), 32'd1);
    chk("t5_sck", 32'(a_sck), 32'd0);
    chk("t5_mosi", 32'(a_mosi), 32'd0);
    chk("t5_busy", 32'(a_busy), 32'd0);
    chk("t5_rx_data", 32'(a_rxd), 32'd0);
    chk("t5_ready", 32'(a_rdy), 32'd1);
    exp_rx.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(cyc, 40, 1'b0);
    chk("t5_no_rxv", ob_rxv_n, 0);
    offer(16'hC33C, 1'b1, 16'hC33C, t0);
    observe(t0, 80, 1'b0);
    chk("t5_after_rxv_count", ob_rxv_n, 1);
    chk("t5_after_rxv_at", ob_rxv_first, 65);

    // DIV=1 back-to-back frames
    sel = 1'b1;
    repeat (3) @(negedge clk);
    offer(16'h8001, 1'b1, 16'h8001, t0);
    offer(16'h7FFE, 1'b1, 16'h7FFE, t0);
    offer(16'h55AA, 1'b1, 16'h55AA, t0);
    offer(16'h0FF0, 1'b1, 16'h0FF0, t0);
    repeat (60) @(negedge clk);
    chk("t6_frames", lo_runs.size(), 4);
    for (int i = 0; i < lo_runs.size(); i++) chk("t6_cs_low_len", lo_runs[i], 33);
    chk("t6_gaps", hi_runs.size(), 3);
    for (int i = 0; i < hi_runs.size(); i++) chk("t6_cs_gap_min2", 32'(hi_runs[i] >= 2), 32'd1);
    chk("t6_queue_drained", exp_rx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hera_spi_initiator.md
# hera_spi_initiator

SPI initiator (host) for the HERA board: the master end of the SPI link whose responder end is the memory manager. It shifts 16-bit words out on MOSI while capturing 16-bit words from MISO, with chip-select framing and a valid/ready word handshake toward the CPU-side logic. It runs entirely in the system clock domain and generates SCK by division.

## Interface
Parameters:
- `WORD_BITS`, default 16: bits per transfer word.
- `DIV`, default 4: SCK half-period in `clk` cycles; must be ≥1.
- `CS_GAP`, default 2: minimum `clk` cycles CS stays high between frames; must be ≥1.

Ports:
- `clk`, in, 1: system clock. All logic is synchronous to it.
- `reset`, in, 1: asynchronous, active-low reset.
- `tx_data`, in, WORD_BITS: word to send, MSB first.
- `tx_last`, in, 1: sampled with `tx_data`; 1 means release CS after this word.
- `tx_valid`, in, 1: the word is offered.
- `tx_ready`, out, 1: the block accepts a word. Transfer occurs on any cycle where `tx_valid && tx_ready`.
- `rx_data`, out, WORD_BITS: last received word; held until the next word completes.
- `rx_valid`, out, 1: one-cycle pulse when `rx_data` updates.
- `busy`, out, 1: high in any state other than IDLE.
- `spi_clk`, out, 1: SCK, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi`, out, 1: serial data out.
- `spi_miso`, in, 1: serial data in.
- `spi_cs`, out, 1: active-low chip select.

## Operation
- States:
  - IDLE: CS high, `tx_ready`=1.
  - SHIFT: transferring a word.
  - CHAINED: CS held low between words, `tx_ready`=1.
  - HOLD: CS low for DIV cycles after the last bit.
  - GAP: CS high for CS_GAP cycles, `tx_ready`=0.
- Transitions:
  - IDLE or CHAINED, handshake → SHIFT. Latch `tx_data` and `tx_last`.
  - SHIFT, bit count done → CHAINED if `tx_last`=0, otherwise HOLD.
  - HOLD, DIV cycles elapsed → GAP.
  - GAP, CS_GAP cycles elapsed → IDLE.
- Each bit lasts 2·DIV cycles: SCK low for DIV cycles, then SCK high for DIV cycles.
- MOSI:
  - Presents the current bit for the whole low and high phase.
  - Changes only on the edge that drives SCK low, or on SHIFT entry.
- MISO:
  - Sampled on the `clk` edge that drives SCK high→low, at the end of the high phase.
  - This gives maximum setup margin to the responder.
  - The sampled bit shifts into the LSB of the receive register.
- Bit counter runs 0..WORD_BITS-1 and does not wrap within a word.
  - Final sample: `rx_data` ← {shift[WORD_BITS-2:0], spi_miso}, `rx_valid`=1 on the same edge.
- `tx_valid` while `tx_ready`=0 is ignored. No data is lost and the source must hold the word.
- CHAINED has no timeout. CS stays low until the next word arrives.
- Reset (async, any state), applied immediately:
  - `spi_cs`=1, `spi_clk`=0, `spi_mosi`=0.
  - `rx_data`=0, `rx_valid`=0, `busy`=0.
  - State = IDLE, so `tx_ready`=1.
- Reset mid-word aborts the frame. No `rx_valid` is produced.

## Timing
- Handshake at cycle T:
  - T+1: CS falls, MOSI = MSB, SCK = 0.
- Bit k (0 = MSB):
  - SCK rises at T+1+2·DIV·k+DIV.
  - SCK falls at T+1+2·DIV·(k+1).
- Last SCK fall and `rx_valid` pulse: T+1+2·DIV·WORD_BITS.
- Same cycle as the last fall:
  - `tx_last`=0: `tx_ready`=1. A handshake at cycle C starts the next MSB at C+1. SCK stays low in between.
  - `tx_last`=1: CS rises DIV cycles after the last fall. `tx_ready` returns CS_GAP cycles after that.
- Defaults (DIV=4, W=16, CS_GAP=2): CS falls T+1, `rx_valid` at T+129, CS rises T+133, `tx_ready`=1 at T+135.
- Outputs `spi_*`, `rx_*` and `busy` are registered. `tx_ready` is decoded from state.

## Structure
- Shared package `hera_spi_pkg`:
  - State enum (IDLE, SHIFT, CHAINED, HOLD, GAP).
  - Default WORD_BITS.
  - SPI mode constants, shared with the memory manager's responder.
- Sub-module `hera_spi_tick`:
  - DIV-cycle down-counter emitting a phase tick.
  - Restarted on SHIFT entry.
- Top holds the FSM and the shift registers.

## Test plan
- DIV=2, CS_GAP=2, MISO looped to MOSI, send 16'hA5C3 with `tx_last`=1 at T:
  - CS low T+1..T+66.
  - 16 SCK pulses.
  - `rx_valid` at T+65 with `rx_data`=16'hA5C3.
  - `tx_ready` back at T+69.
- Responder model returns 16'h3C5A while 16'h1234 is sent:
  - MOSI bit sequence matches 16'h1234 MSB first, sampled at SCK rise.
  - `rx_data`=16'h3C5A.
- Chained 16'h0001 (`tx_last`=0) then 16'hFFFF (`tx_last`=1), second offered 5 cycles late:
  - CS stays low throughout.
  - SCK is low during the 5-cycle wait.
  - Two `rx_valid` pulses.
- `tx_valid` toggled during SHIFT with 16'hDEAD:
  - Ignored.
  - Only the originally accepted word appears on MOSI.
- `reset` asserted at bit 7:
  - CS=1, SCK=0, MOSI=0 within the same cycle.
  - No `rx_valid`.
  - The next word after release transfers correctly.
- DIV=1 back-to-back, 4 words with `tx_last`=1:
  - Each frame lasts 33 cycles of CS low.
  - At least 2 cycles of CS high between frames.
